// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencing controller.
package mc_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALUOP_R      = 3'b000;
  localparam logic [2:0] ALUOP_I      = 3'b001;
  localparam logic [2:0] ALUOP_LOAD   = 3'b010;
  localparam logic [2:0] ALUOP_STORE  = 3'b011;
  localparam logic [2:0] ALUOP_BRANCH = 3'b100;
  localparam logic [2:0] ALUOP_JAL    = 3'b101;
  localparam logic [2:0] ALUOP_LUI    = 3'b110;

  localparam logic [1:0] MTR_ALU  = 2'b00;
  localparam logic [1:0] MTR_MEM  = 2'b01;
  localparam logic [1:0] MTR_LINK = 2'b10;
  localparam logic [1:0] MTR_NONE = 2'b11;

  localparam logic [1:0] PCSRC_PC4    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JAL    = 2'b10;
  localparam logic [1:0] PCSRC_JALR   = 2'b11;

  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       alusrc;
    logic       mux_inp;
    logic [1:0] memtoreg;
    logic [2:0] aluop;
  } sel_t;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode -> datapath select decoder for the multi-cycle core.
module mc_opcode_decode
  import mc_pkg::*;
(
  input  logic [6:0] op_i,
  output sel_t       sel_o,
  output logic       legal_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    sel_o          = '0;
    sel_o.memtoreg = MTR_NONE;
    case (op_i)
      OP_R: begin
        sel_o.memtoreg = MTR_ALU;
        sel_o.aluop    = ALUOP_R;
      end
      OP_I: begin
        sel_o.memtoreg = MTR_ALU;
        sel_o.alusrc   = 1'b1;
        sel_o.aluop    = ALUOP_I;
      end
      OP_LOAD: begin
        sel_o.memtoreg = MTR_MEM;
        sel_o.alusrc   = 1'b1;
        sel_o.aluop    = ALUOP_LOAD;
        sel_o.memread  = 1'b1;
      end
      OP_STORE: begin
        sel_o.memtoreg = MTR_NONE;
        sel_o.alusrc   = 1'b1;
        sel_o.aluop    = ALUOP_STORE;
        sel_o.memwrite = 1'b1;
      end
      OP_BRANCH: begin
        sel_o.memtoreg = MTR_ALU;
        sel_o.aluop    = ALUOP_BRANCH;
        sel_o.branch   = 1'b1;
      end
      OP_JAL: begin
        sel_o.memtoreg = MTR_LINK;
        sel_o.alusrc   = 1'b1;
        sel_o.aluop    = ALUOP_JAL;
      end
      OP_JALR: begin
        sel_o.memtoreg = MTR_LINK;
        sel_o.alusrc   = 1'b1;
        sel_o.aluop    = ALUOP_I;
        sel_o.mux_inp  = 1'b1;
      end
      OP_LUI: begin
        sel_o.memtoreg = MTR_LINK;
        sel_o.alusrc   = 1'b1;
        sel_o.aluop    = ALUOP_LUI;
      end
      OP_AUIPC: begin
        sel_o.memtoreg = MTR_LINK;
        sel_o.alusrc   = 1'b1;
        sel_o.aluop    = ALUOP_R;
      end
      default: ;
    endcase
  end

  assign legal_o = op_legal(op_i);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared memory
// with ready handshake, illegal-opcode trap and memory timeout detection.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       branch,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrc,
  output logic       mux_inp,
  output logic [1:0] memtoreg,
  output logic [2:0] aluop,
  output logic       illegal,
  output logic       bus_error,
  output logic [2:0] state
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_error_q, bus_error_d;

  sel_t sel;
  logic op_q_legal;
  logic timeout;

  mc_opcode_decode u_decode (
    .op_i    (op_q),
    .sel_o   (sel),
    .legal_o (op_q_legal)
  );

  // Timeout only fires when the last allowed wait cycle also misses mem_ready.
  assign timeout = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready && (cnt_q == CNT_MAX);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = '0;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PCSRC_PC4;
    reg_write   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = !timeout;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          bus_error_d = 1'b1;
          state_d     = S_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        op_d = opcode;
        if (op_legal(opcode)) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_EXEC: begin
        if (!op_q_legal) begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end else if (sel.branch) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? PCSRC_BRANCH : PCSRC_PC4;
          state_d  = S_FETCH;
        end else if (sel.memread || sel.memwrite) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = !timeout;
        addr_sel = 1'b1;
        mem_we   = sel.memwrite;
        if (mem_ready) begin
          if (sel.memwrite) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          bus_error_d = 1'b1;
          state_d     = S_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        if (op_q == OP_JAL)       pc_src = PCSRC_JAL;
        else if (op_q == OP_JALR) pc_src = PCSRC_JALR;
        state_d = S_FETCH;
      end
      S_TRAP: ;
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      op_q        <= '0;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign branch    = sel.branch;
  assign memread   = sel.memread;
  assign memwrite  = sel.memwrite;
  assign alusrc    = sel.alusrc;
  assign mux_inp   = sel.mux_inp;
  assign memtoreg  = sel.memtoreg;
  assign aluop     = sel.aluop;
  assign illegal   = illegal_q;
  assign bus_error = bus_error_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-opcode vector table plus
// hand-written multi-cycle sequences (memory wait, illegal trap, timeout).
module tb_multicycle_control;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       branch_taken = 1'b0;
  logic       mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write;
  logic [1:0] pc_src, memtoreg;
  logic       branch, memread, memwrite, alusrc, mux_inp;
  logic [2:0] aluop, state;
  logic       illegal, bus_error;

  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .branch(branch),
    .memread(memread), .memwrite(memwrite), .alusrc(alusrc),
    .mux_inp(mux_inp), .memtoreg(memtoreg), .aluop(aluop),
    .illegal(illegal), .bus_error(bus_error), .state(state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [6:0] op;
    logic       taken;
    int         cycles;
    logic [4:0] flags;   // {branch, memread, memwrite, alusrc, mux_inp}
    logic [1:0] mtr;
    logic [2:0] aluop;
    logic [1:0] pcs;
    int         nreg;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [9:0] sels();
    return {branch, memread, memwrite, alusrc, mux_inp, memtoreg, aluop};
  endfunction

  // Runs one instruction from FETCH with zero memory wait, until FETCH returns.
  task automatic run_instr(input logic [6:0] op, input logic taken,
                           output int cycles, output int nreg, output int npcw,
                           output logic [1:0] pcs, output logic [9:0] s);
    cycles = 0; nreg = 0; npcw = 0; pcs = 2'bxx; s = 'x;
    opcode = op; branch_taken = taken; mem_ready = 1'b1;
    do begin
      #1;
      cycles++;
      if (pc_write === 1'b1) begin npcw++; pcs = pc_src; end
      if (reg_write === 1'b1) nreg++;
      if (state == S_EXEC) s = sels();
      tick();
    end while (state != S_FETCH && cycles < 20);
  endtask

  initial begin
    int cyc, nreg, npcw;
    logic [1:0] pcs;
    logic [9:0] s;
    state_e exp_r[4];
    state_e exp_ld[8];

    vecs[0] = '{OP_R,      1'b0, 4, 5'b00000, 2'b00, 3'b000, 2'b00, 1};
    vecs[1] = '{OP_I,      1'b0, 4, 5'b00010, 2'b00, 3'b001, 2'b00, 1};
    vecs[2] = '{OP_LOAD,   1'b0, 5, 5'b01010, 2'b01, 3'b010, 2'b00, 1};
    vecs[3] = '{OP_STORE,  1'b0, 4, 5'b00110, 2'b11, 3'b011, 2'b00, 0};
    vecs[4] = '{OP_BRANCH, 1'b1, 3, 5'b10000, 2'b00, 3'b100, 2'b01, 0};
    vecs[5] = '{OP_BRANCH, 1'b0, 3, 5'b10000, 2'b00, 3'b100, 2'b00, 0};
    vecs[6] = '{OP_JAL,    1'b0, 4, 5'b00010, 2'b10, 3'b101, 2'b10, 1};
    vecs[7] = '{OP_JALR,   1'b0, 4, 5'b00011, 2'b10, 3'b001, 2'b11, 1};
    vecs[8] = '{OP_LUI,    1'b0, 4, 5'b00010, 2'b10, 3'b110, 2'b00, 1};
    vecs[9] = '{OP_AUIPC,  1'b0, 4, 5'b00010, 2'b10, 3'b000, 2'b00, 1};

    // Reset state
    do_reset();
    #1;
    check("rst state", 32'(state), 32'(S_FETCH));
    check("rst mem_req", 32'(mem_req), 1);
    check("rst enables", 32'({ir_write, pc_write, reg_write, mem_we, addr_sel}), 0);
    check("rst memtoreg", 32'(memtoreg), 32'(2'b11));
    check("rst selects", 32'({branch, memread, memwrite, alusrc, mux_inp, aluop}), 0);
    check("rst flags", 32'({illegal, bus_error}), 0);

    // Per-opcode table, zero-wait memory
    for (int i = 0; i < 10; i++) begin
      do_reset();
      run_instr(vecs[i].op, vecs[i].taken, cyc, nreg, npcw, pcs, s);
      check($sformatf("v%0d cycles", i), 32'(cyc), 32'(vecs[i].cycles));
      check($sformatf("v%0d selects", i), 32'(s), 32'({vecs[i].flags, vecs[i].mtr, vecs[i].aluop}));
      check($sformatf("v%0d pc_src", i), 32'(pcs), 32'(vecs[i].pcs));
      check($sformatf("v%0d reg_write count", i), 32'(nreg), 32'(vecs[i].nreg));
      check($sformatf("v%0d pc_write count", i), 32'(npcw), 1);
    end

    // R-type cycle by cycle
    exp_r = '{S_FETCH, S_DECODE, S_EXEC, S_WB};
    do_reset();
    opcode = OP_R; mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("R state c%0d", c + 1), 32'(state), 32'(exp_r[c]));
      check($sformatf("R reg_write c%0d", c + 1), 32'(reg_write), 32'(c == 3));
      if (c == 3) check("R wb memtoreg/pc_src", 32'({memtoreg, pc_src}), 0);
      tick();
    end
    check("R back to fetch", 32'(state), 32'(S_FETCH));

    // Load with 3 wait cycles in MEM
    exp_ld = '{S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MEM, S_MEM, S_MEM, S_WB};
    do_reset();
    opcode = OP_LOAD;
    for (int c = 1; c <= 8; c++) begin
      mem_ready = !(c >= 4 && c <= 6);
      #1;
      check($sformatf("LD state c%0d", c), 32'(state), 32'(exp_ld[c-1]));
      if (c >= 4 && c <= 7)
        check($sformatf("LD mem req/addr/we c%0d", c), 32'({mem_req, addr_sel, mem_we}), 32'(3'b110));
      if (c == 8) check("LD wb reg_write/memtoreg", 32'({reg_write, memtoreg}), 32'(3'b101));
      tick();
    end
    check("LD 8 cycles", 32'(state), 32'(S_FETCH));

    // Illegal opcode traps after DECODE
    do_reset();
    opcode = 7'b1111111; mem_ready = 1'b1;
    tick();
    #1;
    check("ILL decode", 32'(state), 32'(S_DECODE));
    tick();
    for (int c = 0; c < 4; c++) begin
      mem_ready = c[0];
      #1;
      check($sformatf("ILL trap state c%0d", c), 32'(state), 32'(S_TRAP));
      check($sformatf("ILL trap outs c%0d", c),
            32'({illegal, mem_req, ir_write, pc_write, reg_write}), 32'(5'b10000));
      tick();
    end
    do_reset();
    #1;
    check("ILL reset state", 32'(state), 32'(S_FETCH));
    check("ILL reset flag", 32'(illegal), 0);

    // FETCH timeout with TIMEOUT_CYCLES=4
    do_reset();
    opcode = OP_R; mem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check($sformatf("TO wait c%0d", c), 32'({state, mem_req}), 32'({S_FETCH, 1'b1}));
      tick();
    end
    #1;
    check("TO c5 mem_req drops", 32'({mem_req, ir_write}), 0);
    tick();
    #1;
    check("TO trap state", 32'(state), 32'(S_TRAP));
    check("TO bus_error", 32'({bus_error, mem_req}), 32'(2'b10));

    // mem_ready on the timeout cycle completes normally
    do_reset();
    mem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    mem_ready = 1'b1;
    #1;
    check("TO-rdy c5 req/ir_write", 32'({mem_req, ir_write}), 32'(2'b11));
    tick();
    #1;
    check("TO-rdy decode", 32'(state), 32'(S_DECODE));
    check("TO-rdy no bus_error", 32'(bus_error), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
